// File: rtl/bp_jtag_player.sv
// bp_jtag_player
// RBCP slave that buffers packed TMS/TDI bytes in a FIFO and replays them on
// one of NCHAN JTAG chains with a run-time programmable TCK half-period.
// Optional macro BP_JTAG_TDO_CAPTURE_EN builds TDO capture (register 0x04);
// without it JTAG_TDO is ignored and 0x04 reads 0.

module bp_jtag_player #(
  parameter int          FIFO_AW   = 10,
  parameter int          NCHAN     = 2,
  parameter int          DIV_INIT  = 1,
  parameter logic [19:0] BASE_ADDR = 20'd2
) (
  input  logic             CLK_133m,
  input  logic             RST_N,
  input  logic             RBCP_ACT,
  input  logic [31:0]      RBCP_ADDR,
  input  logic             RBCP_WE,
  input  logic [7:0]       RBCP_WD,
  input  logic             RBCP_RE,
  output logic [7:0]       RBCP_RD,
  output logic             RBCP_ACK,
  output logic [NCHAN-1:0] JTAG_TCK,
  output logic [NCHAN-1:0] JTAG_TMS,
  output logic [NCHAN-1:0] JTAG_TDI,
  input  logic [NCHAN-1:0] JTAG_TDO
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CSW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  // One slot stays unused so a full FIFO holds DEPTH-1 bytes.
  localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW+1)'(DEPTH - 1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_HIGH = 2'd3;

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h01;
  localparam logic [7:0] A_CHSEL  = 8'h02;
  localparam logic [7:0] A_DIV    = 8'h03;
  localparam logic [7:0] A_TDO    = 8'h04;
  localparam logic [7:0] A_LEVEL  = 8'h05;
  localparam logic [7:0] A_CTRL   = 8'h06;

  // RBCP stage 1
  logic        r_we, r_re;
  logic [31:0] r_addr;
  logic [7:0]  r_wd;
  // RBCP stage 2 outputs
  logic        r_ack;
  logic [7:0]  r_rd;
  // Configuration / status
  logic [CSW-1:0] r_chsel;
  logic [7:0]     r_div;
  logic           r_ovf;
  // FIFO
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_count;
  // Engine
  logic [1:0]     r_state;
  logic [7:0]     r_cnt;
  logic [1:0]     r_pair;
  logic [7:0]     r_byte;
  logic [CSW-1:0] r_act;
  logic           r_tms, r_tdi;

  logic        w_sel, w_wr, w_rd;
  logic [7:0]  w_reg;
  logic        w_full, w_empty, w_busy;
  logic        w_push_req, w_push, w_pop, w_flush, w_ovf_clr;
  logic [7:0]  w_head;
  logic [31:0] w_count32;
  logic [7:0]  w_level;
  logic [7:0]  w_status;
  logic [7:0]  w_rdata;
  logic [7:0]  w_tdo_reg;
  logic [1:0]  w_pair_nx;
  logic        w_act_ok;
  logic        w_last_high;

  assign w_sel = (r_addr[31:12] == BASE_ADDR);
  assign w_reg = r_addr[7:0];
  assign w_wr  = r_we & w_sel;
  assign w_rd  = r_re & w_sel;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LVL);
  assign w_busy  = (r_state != S_IDLE);

  assign w_flush    = w_wr && (w_reg == A_CTRL) && r_wd[1];
  assign w_ovf_clr  = w_wr && (w_reg == A_CTRL) && r_wd[0];
  assign w_push_req = w_wr && (w_reg == A_DATA);
  assign w_push     = w_push_req && !w_full && !w_flush;
  assign w_pop      = (r_state == S_LOAD) && !w_empty;
  assign w_head     = r_mem[r_rp];

  assign w_count32 = 32'(r_count);
  assign w_level   = (w_count32 > 32'd255) ? 8'hFF : w_count32[7:0];
  assign w_status  = {4'b0000, r_ovf, w_busy, w_full, w_empty};

  assign w_pair_nx   = r_pair + 2'd1;
  assign w_act_ok    = (32'(r_act) < NCHAN);
  assign w_last_high = (r_state == S_HIGH) && (r_cnt == 8'd0);

  // Register the qualified RBCP strobes, address and write data once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N) begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_addr <= '0;
      r_wd   <= '0;
    end else begin
      r_we   <= RBCP_WE & RBCP_ACT;
      r_re   <= RBCP_RE & RBCP_ACT;
      r_addr <= RBCP_ADDR;
      r_wd   <= RBCP_WD;
    end
  end

  // Read mux for the decoded register address.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rdata = 8'h00;
    case (w_reg)
      A_STATUS: w_rdata = w_status;
      A_CHSEL:  w_rdata = {{(8-CSW){1'b0}}, r_chsel};
      A_DIV:    w_rdata = r_div;
      A_TDO:    w_rdata = w_tdo_reg;
      A_LEVEL:  w_rdata = w_level;
      default:  w_rdata = 8'h00;
    endcase
  end

  // Acknowledge one cycle after decode; read data is zero outside ACK.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N) begin
      r_ack <= 1'b0;
      r_rd  <= 8'h00;
    end else begin
      r_ack <= w_wr | w_rd;
      r_rd  <= w_rd ? w_rdata : 8'h00;
    end
  end

  assign RBCP_ACK = r_ack;
  assign RBCP_RD  = r_rd;

  // Writable configuration and the sticky overflow flag.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N) begin
      r_chsel <= '0;
      r_div   <= 8'(DIV_INIT);
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr && (w_reg == A_CHSEL)) r_chsel <= r_wd[CSW-1:0];
      if (w_wr && (w_reg == A_DIV))   r_div   <= r_wd;
      if (w_ovf_clr)
        r_ovf <= 1'b0;
      else if (w_push_req && w_full && !w_flush)
        r_ovf <= 1'b1;
    end
  end

  // FIFO pointers and fill count; flush wins over push and pop.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage array.
  // NOTE: the memory has no reset; the pointers alone define valid contents.
  always_ff @(posedge CLK_133m) begin
    if (w_push) r_mem[r_wp] <= r_wd;
  end

  // Engine FSM: pop a byte, then play four LOW/HIGH TCK cycles from it.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_pair  <= 2'd0;
      r_byte  <= 8'd0;
      r_act   <= '0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          // A flush between the decision and this cycle leaves nothing to pop.
          if (w_empty) begin
            r_state <= S_IDLE;
          end else begin
            r_byte  <= w_head;
            r_act   <= r_chsel;
            r_pair  <= 2'd0;
            r_tms   <= w_head[0];
            r_tdi   <= w_head[1];
            r_cnt   <= r_div;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (r_cnt == 8'd0) begin
            r_cnt   <= r_div;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == 8'd0) begin
            if (r_pair != 2'd3) begin
              r_pair  <= w_pair_nx;
              r_tms   <= r_byte[{w_pair_nx, 1'b0}];
              r_tdi   <= r_byte[{w_pair_nx, 1'b1}];
              r_cnt   <= r_div;
              r_state <= S_LOW;
            end else if (!w_empty) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Steer the engine onto the active chain; all others stay parked.
  always_comb begin
    JTAG_TCK = '0;
    JTAG_TMS = '1;
    JTAG_TDI = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (w_act_ok && (32'(r_act) == i)) begin
        JTAG_TCK[i] = (r_state == S_HIGH);
        JTAG_TMS[i] = r_tms;
        JTAG_TDI[i] = r_tdi;
      end
    end
  end

`ifdef BP_JTAG_TDO_CAPTURE_EN
  logic [7:0] r_tdo;
  logic       w_tdo_bit;
  logic       w_unused;

  // Select TDO of the active chain.
  always_comb begin
    w_tdo_bit = 1'b0;
    if (w_act_ok) w_tdo_bit = JTAG_TDO[r_act];
  end

  // Shift TDO in on the last clock of each HIGH phase; newest bit is bit 0.
  always_ff @(posedge CLK_133m or negedge RST_N) begin
    if (!RST_N)
      r_tdo <= 8'h00;
    else if (w_last_high)
      r_tdo <= {r_tdo[6:0], w_tdo_bit};
  end

  assign w_tdo_reg = r_tdo;
  assign w_unused  = ^r_addr[11:8];
`else
  logic w_unused;

  assign w_tdo_reg = 8'h00;
  assign w_unused  = ^{r_addr[11:8], JTAG_TDO, w_last_high};
`endif

endmodule

// File: doc/bp_jtag_player.md
# bp_jtag_player

RBCP-controlled JTAG player that sits on the backplane controller next to the other RBCP slaves. It accepts a byte stream of packed TMS/TDI vectors over RBCP, buffers it in an internal FIFO and replays it on one of NCHAN selectable JTAG chains. The TCK rate is programmable at run time, and TDO is captured for readback. It supersedes the fixed-rate, single-chain FIFO-to-JTAG path. It adds chain selection, a programmable divider, fill-level and overflow status, and a flush control.

## Interface
Parameters:
- FIFO_AW, 10: FIFO address width; depth = 2^FIFO_AW bytes.
- NCHAN, 2: number of JTAG chains (1..8).
- DIV_INIT, 1: reset value of the TCK divider register.
- BASE_ADDR, 20'd2: block selected when RBCP_ADDR[31:12] == BASE_ADDR.

Ports:
- CLK_133m  in  1  system clock, 133 MHz; single clock domain.
- RST_N  in  1  reset, asynchronous assert, active-low.
- RBCP_ACT  in  1  RBCP active (unused beyond pass-through qualification).
- RBCP_ADDR  in  32  RBCP address.
- RBCP_WE  in  1  RBCP write strobe.
- RBCP_WD  in  8  RBCP write data.
- RBCP_RE  in  1  RBCP read strobe.
- RBCP_RD  out  8  read data; valid only while RBCP_ACK is high, 0 otherwise.
- RBCP_ACK  out  1  one-cycle acknowledge.
- JTAG_TCK  out  NCHAN  per-chain TCK.
- JTAG_TMS  out  NCHAN  per-chain TMS.
- JTAG_TDI  out  NCHAN  per-chain TDI.
- JTAG_TDO  in  NCHAN  per-chain TDO.

## Operation
Register map, decoded on RBCP_ADDR[7:0] when the block is selected:
- 0x00 W DATA: push RBCP_WD into the FIFO. If the FIFO is full, the byte is dropped, the sticky OVF flag is set, and the write is still acknowledged.
- 0x01 R STATUS: {4'b0, OVF, BUSY, FULL, EMPTY}.
- 0x02 R/W CHSEL: selected chain index, low $clog2(NCHAN) bits. An index ≥ NCHAN selects no chain. Reset value 0.
- 0x03 R/W DIV: TCK half-period = DIV+1 clocks. Reset value DIV_INIT.
- 0x04 R TDO: last 8 captured TDO bits; the newest bit is bit 0.
- 0x05 R LEVEL: FIFO fill count. This is the low 8 bits, saturating at 255.
- 0x06 W CTRL: bit0=1 clears OVF; bit1=1 flushes the FIFO.
- Any other address: writes are acknowledged and ignored; reads return 0.

Byte format: 4 JTAG cycles per byte, consumed LSB pair first. Pair k is bits[2k+1:2k], with TMS=bit 2k and TDI=bit 2k+1.

Engine FSM:
- IDLE: TCK=0. Moves to LOAD when the FIFO is not empty.
- LOAD: pops one byte, latches CHSEL into the active channel, sets pair=0, then goes to LOW.
- LOW: drives TMS/TDI from the current pair with TCK=0 for DIV+1 clocks, then goes to HIGH.
- HIGH: TCK=1 for DIV+1 clocks. TDO of the active chain is sampled on the last clock of HIGH and shifted into the TDO register. Next state:
  - LOW with pair+1 if pair<3.
  - LOAD if pair==3 and the FIFO is not empty.
  - IDLE otherwise.
- BUSY is high in every state except IDLE.

Channel outputs:
- Inactive chains: TCK=0, TMS=1, TDI=0.
- A CHSEL write takes effect at the next LOAD only.

Boundary behaviour:
- Simultaneous push and pop: the count is unchanged; no spurious FULL or EMPTY.
- Flush: clears the FIFO and LEVEL. An in-flight byte finishes its 4 cycles, then the engine goes to IDLE.
- A push in the same cycle as a flush is discarded.
- DIV written while BUSY applies from the next phase start.

## Timing
- Reset values: RBCP_ACK=0, RBCP_RD=0, JTAG_TCK=0, JTAG_TMS=all 1, JTAG_TDI=0. FIFO is empty, OVF=0, TDO register=0, FSM=IDLE.
- Reset asserted mid-operation aborts the engine immediately and restores the reset values above.
- RBCP strobes are registered once and decoded once. RBCP_ACK is high exactly 2 cycles after the WE/RE cycle, for 1 cycle. RBCP_RD is valid in that same cycle.
- A pushed byte reaches LOAD no earlier than 3 cycles after the WE cycle.
- TCK period = 2·(DIV+1) clocks; DIV=1 gives 33.25 MHz.
- One byte takes 8·(DIV+1) clocks, plus 1 LOAD clock between bytes.
- TMS/TDI change only at LOW entry; TCK rises DIV+1 clocks later, giving half a TCK period of setup.

## Configuration
- Macro BP_JTAG_TDO_CAPTURE_EN.
- Defined: the TDO shift register and TDO mux are built, and register 0x04 returns the captured bits.
- Undefined: no TDO logic is built, JTAG_TDO is ignored, and 0x04 reads 0. All other behaviour is identical.

## Test plan
- Reset, then read 0x01 -> RD=8'h01, ACK 2 cycles after RE. All TMS=1, TCK=0.
- DIV=1, CHSEL=0, write 8'hB4 -> chain 0 shows 4 TCK pulses with period 4 clocks. TMS sequence is 0,1,1,0 and TDI sequence is 0,0,1,1. Chain 1 stays idle. BUSY then falls and EMPTY rises.
- With FIFO_AW=4, write 17 bytes while DIV=255 (engine stalled on the first byte) -> all 17 are acknowledged. Exactly 1 byte is dropped, STATUS has OVF=1, and LEVEL=15. A CTRL write of 8'h01 clears OVF.
- With BP_JTAG_TDO_CAPTURE_EN defined, tie JTAG_TDO[1]=1, set CHSEL=1 and write 2 bytes -> 0x04 reads 8'hFF. With the macro undefined, 0x04 reads 8'h00.
- While byte 1 of 3 is shifting, write CHSEL=1 and CTRL=8'h02 -> byte 1 completes on chain 0, nothing appears on chain 1, and LEVEL=0.
- Deassert then assert reset in the middle of a HIGH phase -> TCK drops to 0 in the same cycle, and the FIFO is empty after reset is released.
